pixel_on_segments: RTL and testbench
====================================

PIXEL_ON_SEGMENTS -- requirements
Module: pixel_on_segments

Interface
REQ-001 SHALL have parameter W, default 32: signed fixed-point word width.
REQ-002 SHALL have parameter FRAC, default 16: fractional bits (Q(W-FRAC).FRAC).
REQ-003 SHALL have parameter NSEG, default 8: segment table depth, power of two, at least 2.
REQ-004 SHALL have parameter LINE_WIDTH_SQR, default 32'h0001_0000 (1.0): hit threshold on squared distance.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have ports seg_we (1), seg_addr (log2 NSEG), seg_x0, seg_y0, seg_xn, seg_yn, seg_mag (W each), all inputs: segment table write.
REQ-008 SHALL have port seg_wr_ready, output, 1: table write accepted this cycle.
REQ-009 SHALL have ports n_active, input, log2(NSEG)+1: number of segments to scan.
REQ-010 SHALL have ports in_valid (input, 1), in_ready (output, 1), in_x and in_y (inputs, W each): pixel request.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_hit (output, 1), out_idx (output, log2 NSEG): result.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; seg_wr_ready SHALL be 1 in IDLE and DONE, 0 in SCAN.
REQ-014 A table write SHALL occur when seg_we && seg_wr_ready; writes in SCAN SHALL be dropped.
REQ-015 In IDLE, in_valid && in_ready SHALL capture in_x, in_y and min(n_active, NSEG) and set the scan index to 0.
REQ-016 On capture, the FSM SHALL enter SCAN if the captured count is nonzero, else DONE with out_hit=0 and out_idx=0.
REQ-017 SCAN SHALL evaluate exactly one segment, at the scan index, per cycle.
REQ-018 Per segment: dx=x-x0, dy=y-y0, dot=(dx*xn+dy*yn)>>>FRAC, px=x0+((xn*dot)>>>FRAC), py=y0+((yn*dot)>>>FRAC), d2=((x-px)^2+(y-py)^2)>>>FRAC.
REQ-019 Every product and sum SHALL be computed at 2W signed; every shift SHALL be arithmetic; results SHALL be truncated to W bits, with no saturation.
REQ-020 A segment SHALL hit iff 0 <= dot <= mag and d2 <= LINE_WIDTH_SQR, with all comparisons signed.
REQ-021 On the first hit, the FSM SHALL go to DONE with out_hit=1 and out_idx set to that index (lowest hitting index wins).
REQ-022 If the last active index misses, the FSM SHALL go to DONE with out_hit=0 and out_idx=0.
REQ-023 Latency, for a capture at edge T with count n: no hit gives out_valid at T+n+1; hit at index i gives out_valid at T+i+2; n=0 gives out_valid at T+1.
REQ-024 out_valid SHALL be 1 exactly in DONE; out_hit and out_idx SHALL hold stable while out_valid && !out_ready.
REQ-025 out_valid && out_ready SHALL return the FSM to IDLE on that edge; the next capture is possible one cycle later.
REQ-026 Table writes in DONE SHALL affect only subsequent pixels, never the held result.
REQ-027 A change of n_active after capture SHALL NOT affect the scan in progress.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, out_valid=0, out_hit=0, out_idx=0, scan index 0 and all table entries 0, regardless of clk.
REQ-029 Reset asserted mid-SCAN or in DONE SHALL abort the request with no result emitted.
REQ-030 After reset, in_ready=1 and seg_wr_ready=1.

Verification
REQ-031 Seg0: x0=y0=0, xn=0x10000, yn=0, mag=0xA0000; n_active=1; pixel (0x50000, 0x08000) -> out_hit=1, out_idx=0, out_valid 2 cycles after capture.
REQ-032 Same segment, pixel (0x50000, 0x20000) (d2=4.0) -> out_hit=0; pixel (0xC0000, 0) (dot=12>mag) -> out_hit=0; pixel (0xFFFF0000, 0) (dot=-1) -> out_hit=0.
REQ-033 NSEG=8 table, only seg5 matching, n_active=8 -> out_idx=5, out_valid 7 cycles after capture; same with n_active=5 -> out_hit=0 at 6 cycles.
REQ-034 n_active=0 -> out_valid=1, out_hit=0 one cycle after capture; n_active=15 behaves exactly as 8.
REQ-035 Hold out_ready=0 for 10 cycles while issuing seg_we writes -> result stable, writes land; seg_we during SCAN -> table unchanged.
REQ-036 Assert rst_n low mid-SCAN -> out_valid stays 0, in_ready=1, all table reads return 0.

Source files
------------

// File: rtl/pixel_on_segments.sv
// Tests one pixel against a table of line segments, one segment per clock.
// Reports whether the pixel lies on a segment and, if so, the lowest such index.
module pixel_on_segments #(
  parameter int W              = 32,
  parameter int FRAC           = 16,
  parameter int NSEG           = 8,
  parameter logic [W-1:0] LINE_WIDTH_SQR = W'(32'h0001_0000)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      seg_we,
  input  logic [$clog2(NSEG)-1:0]   seg_addr,
  input  logic [W-1:0]              seg_x0,
  input  logic [W-1:0]              seg_y0,
  input  logic [W-1:0]              seg_xn,
  input  logic [W-1:0]              seg_yn,
  input  logic [W-1:0]              seg_mag,
  output logic                      seg_wr_ready,
  input  logic [$clog2(NSEG):0]     n_active,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              in_x,
  input  logic [W-1:0]              in_y,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_hit,
  output logic [$clog2(NSEG)-1:0]   out_idx
);

  localparam int AW = $clog2(NSEG);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;

  logic [W-1:0] tab_x0  [NSEG];
  logic [W-1:0] tab_y0  [NSEG];
  logic [W-1:0] tab_xn  [NSEG];
  logic [W-1:0] tab_yn  [NSEG];
  logic [W-1:0] tab_mag [NSEG];

  logic [W-1:0]  cap_x;
  logic [W-1:0]  cap_y;
  logic [AW:0]   cap_cnt;
  logic [AW-1:0] scan_idx;

  logic [AW:0]   n_clamped;
  logic          last_idx;
  logic          seg_hit;

  logic signed [2*W-1:0] dx, dy, dot_sum, proj_x, proj_y, ex, ey, d2_sum;
  logic signed [W-1:0]   dot, px, py, d2;

  function automatic logic signed [2*W-1:0] sext(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v};
  endfunction

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign seg_wr_ready = (state != SCAN);

  assign n_clamped = (n_active > (AW+1)'(NSEG)) ? (AW+1)'(NSEG) : n_active;
  assign last_idx  = ({1'b0, scan_idx} == (cap_cnt - (AW+1)'(1)));

  // Projection of the pixel onto the segment line; all intermediates held at 2W
  // and each named result wraps to W bits.
  always_comb begin
    dx      = sext(cap_x) - sext(tab_x0[scan_idx]);
    dy      = sext(cap_y) - sext(tab_y0[scan_idx]);
    dot_sum = dx * sext(tab_xn[scan_idx]) + dy * sext(tab_yn[scan_idx]);
    dot     = W'(dot_sum >>> FRAC);
    proj_x  = sext(tab_x0[scan_idx]) + ((sext(tab_xn[scan_idx]) * sext(dot)) >>> FRAC);
    proj_y  = sext(tab_y0[scan_idx]) + ((sext(tab_yn[scan_idx]) * sext(dot)) >>> FRAC);
    px      = W'(proj_x);
    py      = W'(proj_y);
    ex      = sext(cap_x) - sext(px);
    ey      = sext(cap_y) - sext(py);
    d2_sum  = ex * ex + ey * ey;
    d2      = W'(d2_sum >>> FRAC);
    seg_hit = !dot[W-1]
              && (dot <= $signed(tab_mag[scan_idx]))
              && (d2 <= $signed(LINE_WIDTH_SQR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NSEG; i++) begin
        tab_x0[i]  <= '0;
        tab_y0[i]  <= '0;
        tab_xn[i]  <= '0;
        tab_yn[i]  <= '0;
        tab_mag[i] <= '0;
      end
    end else if (seg_we && seg_wr_ready) begin
      tab_x0[seg_addr]  <= seg_x0;
      tab_y0[seg_addr]  <= seg_y0;
      tab_xn[seg_addr]  <= seg_xn;
      tab_yn[seg_addr]  <= seg_yn;
      tab_mag[seg_addr] <= seg_mag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap_x    <= '0;
      cap_y    <= '0;
      cap_cnt  <= '0;
      scan_idx <= '0;
      out_hit  <= 1'b0;
      out_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap_x    <= in_x;
            cap_y    <= in_y;
            cap_cnt  <= n_clamped;
            scan_idx <= '0;
            if (n_clamped == '0) begin
              state   <= DONE;
              out_hit <= 1'b0;
              out_idx <= '0;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (seg_hit) begin
            state   <= DONE;
            out_hit <= 1'b1;
            out_idx <= scan_idx;
          end else if (last_idx) begin
            state   <= DONE;
            out_hit <= 1'b0;
            out_idx <= '0;
          end else begin
            scan_idx <= scan_idx + AW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_on_segments.sv
// Directed bench for pixel_on_segments: hand-computed Q16.16 vectors, latency,
// hold, write-drop and reset-abort scenarios.
module tb_pixel_on_segments;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seg_we;
  logic [2:0]  seg_addr;
  logic [31:0] seg_x0, seg_y0, seg_xn, seg_yn, seg_mag;
  logic        seg_wr_ready;
  logic [3:0]  n_active;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x, in_y;
  logic        out_valid;
  logic        out_ready;
  logic        out_hit;
  logic [2:0]  out_idx;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pixel_on_segments #(
    .W              (32),
    .FRAC           (16),
    .NSEG           (8),
    .LINE_WIDTH_SQR (32'h0001_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_we       (seg_we),
    .seg_addr     (seg_addr),
    .seg_x0       (seg_x0),
    .seg_y0       (seg_y0),
    .seg_xn       (seg_xn),
    .seg_yn       (seg_yn),
    .seg_mag      (seg_mag),
    .seg_wr_ready (seg_wr_ready),
    .n_active     (n_active),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_hit      (out_hit),
    .out_idx      (out_idx)
  );

  task automatic write_seg(input logic [2:0] a, input logic [31:0] x0, y0, xn, yn, mag);
    @(negedge clk);
    seg_we = 1'b1; seg_addr = a;
    seg_x0 = x0; seg_y0 = y0; seg_xn = xn; seg_yn = yn; seg_mag = mag;
    @(posedge clk);
    #1 seg_we = 1'b0;
  endtask

  // Only seg5 (x0=100, along +x, length 10) lies near pixel (105, 0).
  task automatic load_table();
    for (int i = 0; i < 8; i++) begin
      if (i == 5) write_seg(3'(i), 32'h0064_0000, 32'h0, 32'h0001_0000, 32'h0, 32'h000A_0000);
      else        write_seg(3'(i), 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    end
  endtask

  // Capture a pixel, then scramble n_active; lat is the edge count after the
  // capture edge at which out_valid is first seen, 0 if it never arrives.
  task automatic run_pixel(input logic [31:0] x, y, input logic [3:0] n,
                           output int lat, output logic hit, output logic [2:0] idx);
    @(negedge clk);
    in_x = x; in_y = y; n_active = n; in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      n_active = 4'd1;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    hit = out_hit;
    idx = out_idx;
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({out_valid, out_hit, out_idx, in_ready, seg_wr_ready} !== 7'b0_0_000_1_1) begin
      miscompares++;
      $display("FAIL reset_state got v=%b h=%b i=%0d ir=%b wr=%b want v=0 h=0 i=0 ir=1 wr=1",
               out_valid, out_hit, out_idx, in_ready, seg_wr_ready);
    end
  endtask

  task automatic test_basic_hit();
    int lat; logic hit; logic [2:0] idx;
    write_seg(3'd0, 32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h000A_0000);
    run_pixel(32'h0005_0000, 32'h0000_8000, 4'd1, lat, hit, idx);
    vectors++;
    if ({8'(lat), hit, idx} !== {8'd2, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL basic_hit got lat=%0d hit=%b idx=%0d want lat=2 hit=1 idx=0", lat, hit, idx);
    end
    vectors++;
    if ({in_ready, seg_wr_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL done_ready got in_ready=%b seg_wr_ready=%b want 0 1", in_ready, seg_wr_ready);
    end
    accept();
    @(negedge clk);
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL after_accept got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_misses();
    logic [31:0] xs [3] = '{32'h0005_0000, 32'h000C_0000, 32'hFFFF_0000};
    logic [31:0] ys [3] = '{32'h0002_0000, 32'h0000_0000, 32'h0000_0000};
    int lat; logic hit; logic [2:0] idx;
    for (int v = 0; v < 3; v++) begin
      run_pixel(xs[v], ys[v], 4'd1, lat, hit, idx);
      vectors++;
      if ({8'(lat), hit, idx} !== {8'd2, 1'b0, 3'd0}) begin
        miscompares++;
        $display("FAIL miss_%0d got lat=%0d hit=%b idx=%0d want lat=2 hit=0 idx=0", v, lat, hit, idx);
      end
      accept();
    end
  endtask

  task automatic test_scan_depth();
    logic [3:0] ns   [4] = '{4'd8, 4'd5, 4'd15, 4'd0};
    int         elat [4] = '{7, 6, 7, 1};
    logic       ehit [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] eidx [4] = '{3'd5, 3'd0, 3'd5, 3'd0};
    int lat; logic hit; logic [2:0] idx;
    load_table();
    for (int v = 0; v < 4; v++) begin
      run_pixel(32'h0069_0000, 32'h0, ns[v], lat, hit, idx);
      vectors++;
      if ({8'(lat), hit, idx} !== {8'(elat[v]), ehit[v], eidx[v]}) begin
        miscompares++;
        $display("FAIL depth_n%0d got lat=%0d hit=%b idx=%0d want lat=%0d hit=%b idx=%0d",
                 ns[v], lat, hit, idx, elat[v], ehit[v], eidx[v]);
      end
      accept();
    end
  endtask

  task automatic test_scan_write_drop();
    int lat; logic hit; logic [2:0] idx;
    logic seen;
    @(negedge clk);
    in_x = 32'h0069_0000; in_y = 32'h0; n_active = 4'd8; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    seg_we = 1'b1; seg_addr = 3'd5;
    seg_x0 = '0; seg_y0 = '0; seg_xn = '0; seg_yn = '0; seg_mag = '0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (seg_wr_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL scan_wr_ready_%0d got %b want 0", i, seg_wr_ready);
      end
    end
    @(negedge clk);
    seg_we = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid === 1'b1) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    vectors++;
    if ({seen, out_hit, out_idx} !== {1'b1, 1'b1, 3'd5}) begin
      miscompares++;
      $display("FAIL scan_write_result got valid=%b hit=%b idx=%0d want 1 1 5", seen, out_hit, out_idx);
    end
    accept();
    run_pixel(32'h0069_0000, 32'h0, 4'd8, lat, hit, idx);
    vectors++;
    if ({8'(lat), hit, idx} !== {8'd7, 1'b1, 3'd5}) begin
      miscompares++;
      $display("FAIL scan_write_dropped got lat=%0d hit=%b idx=%0d want lat=7 hit=1 idx=5", lat, hit, idx);
    end
    accept();
  endtask

  task automatic test_hold_and_write();
    int lat; logic hit; logic [2:0] idx;
    write_seg(3'd0, 32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h000A_0000);
    run_pixel(32'h0005_0000, 32'h0000_8000, 4'd1, lat, hit, idx);
    vectors++;
    if ({8'(lat), hit, idx} !== {8'd2, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL hold_setup got lat=%0d hit=%b idx=%0d want lat=2 hit=1 idx=0", lat, hit, idx);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seg_we = 1'b1; seg_addr = 3'(i);
      seg_x0 = '0; seg_y0 = '0; seg_xn = '0; seg_yn = '0; seg_mag = '0;
      vectors++;
      if ({out_valid, out_hit, out_idx, seg_wr_ready} !== {1'b1, 1'b1, 3'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL hold_cycle_%0d got v=%b h=%b i=%0d wr=%b want 1 1 0 1",
                 i, out_valid, out_hit, out_idx, seg_wr_ready);
      end
    end
    @(posedge clk);
    #1 seg_we = 1'b0;
    accept();
    run_pixel(32'h0005_0000, 32'h0000_8000, 4'd1, lat, hit, idx);
    vectors++;
    if ({8'(lat), hit, idx} !== {8'd2, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL hold_writes_landed got lat=%0d hit=%b idx=%0d want lat=2 hit=0 idx=0", lat, hit, idx);
    end
    accept();
  endtask

  task automatic test_reset_mid_scan();
    int lat; logic hit; logic [2:0] idx;
    logic seen;
    load_table();
    write_seg(3'd0, 32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h000A_0000);
    @(negedge clk);
    in_x = 32'h0069_0000; in_y = 32'h0; n_active = 4'd8; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_hit, out_idx, in_ready, seg_wr_ready} !== 7'b0_0_000_1_1) begin
      miscompares++;
      $display("FAIL reset_async got v=%b h=%b i=%0d ir=%b wr=%b want v=0 h=0 i=0 ir=1 wr=1",
               out_valid, out_hit, out_idx, in_ready, seg_wr_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_result got out_valid seen=%b want 0", seen);
    end
    run_pixel(32'h0005_0000, 32'h0000_8000, 4'd1, lat, hit, idx);
    vectors++;
    if ({8'(lat), hit, idx} !== {8'd2, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_seg0_cleared got lat=%0d hit=%b idx=%0d want lat=2 hit=0 idx=0", lat, hit, idx);
    end
    accept();
    run_pixel(32'h0069_0000, 32'h0, 4'd8, lat, hit, idx);
    vectors++;
    if ({8'(lat), hit, idx} !== {8'd9, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_seg5_cleared got lat=%0d hit=%b idx=%0d want lat=9 hit=0 idx=0", lat, hit, idx);
    end
    accept();
    run_pixel(32'h0, 32'h0, 4'd8, lat, hit, idx);
    vectors++;
    if ({8'(lat), hit, idx} !== {8'd2, 1'b1, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_zero_seg_origin got lat=%0d hit=%b idx=%0d want lat=2 hit=1 idx=0", lat, hit, idx);
    end
    accept();
  endtask

  initial begin
    rst_n = 1'b0; seg_we = 1'b0; seg_addr = '0;
    seg_x0 = '0; seg_y0 = '0; seg_xn = '0; seg_yn = '0; seg_mag = '0;
    n_active = '0; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_basic_hit();
    test_misses();
    test_scan_depth();
    test_scan_write_drop();
    test_hold_and_write();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
